// File: rtl/bram_port_initiator_pkg.sv
// Shared types for the BRAM port initiator: controller states, response record
// and response-buffer sizing.
package bram_port_initiator_pkg;

  typedef enum logic [1:0] {
    INIT,
    SCRUB,
    RUN
  } state_t;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  localparam int unsigned RSP_FIFO_DEPTH = 4;
  localparam int unsigned RSP_PTR_W      = $clog2(RSP_FIFO_DEPTH);
  localparam int unsigned RSP_CNT_W      = RSP_PTR_W + 1;

endpackage

// File: rtl/bram_rsp_fifo.sv
// First-word-fall-through response buffer: the head entry is visible on
// pop_data_o whenever valid_o is high. Depth must be a power of two.
module bram_rsp_fifo
  import bram_port_initiator_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 push_i,
  input  rsp_t                 push_data_i,
  input  logic                 pop_i,
  output rsp_t                 pop_data_o,
  output logic                 valid_o,
  output logic [RSP_CNT_W-1:0] count_o
);

  rsp_t                 mem_q [RSP_FIFO_DEPTH];
  logic [RSP_PTR_W-1:0] wr_ptr_q;
  logic [RSP_PTR_W-1:0] rd_ptr_q;
  logic [RSP_CNT_W-1:0] count_q;
  logic                 pop_en;

  assign valid_o    = (count_q != '0);
  assign pop_en     = pop_i & valid_o;
  assign pop_data_o = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o    = count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + RSP_CNT_W'(push_i) - RSP_CNT_W'(pop_en);
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (push_i && !rst_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/bram_port_initiator.sv
// Request/response front end for one BRAM port: registered BRAM drive, 2-cycle
// read pipeline, in-order response FIFO. Define BRAM_INIT_SCRUB_EN to zero the
// whole memory after every reset before accepting requests.
module bram_port_initiator
  import bram_port_initiator_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR    = 32'h00000000,
  parameter logic [31:0] C_HIGHADDR    = 32'h00003FFF,
  parameter int unsigned C_MEMSIZE     = 'h4000,
  parameter int unsigned C_PORT_DWIDTH = 32,
  parameter int unsigned C_PORT_AWIDTH = 32,
  parameter int unsigned C_NUM_WE      = 4
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     Req_Valid,
  output logic                     Req_Ready,
  input  logic                     Req_Write,
  input  logic [C_PORT_AWIDTH-1:0] Req_Addr,
  input  logic [C_PORT_DWIDTH-1:0] Req_Data,
  input  logic [C_NUM_WE-1:0]      Req_BE,
  output logic                     Rsp_Valid,
  input  logic                     Rsp_Ready,
  output logic [C_PORT_DWIDTH-1:0] Rsp_Data,
  output logic                     Rsp_Err,
  output logic                     Init_Done,
  output logic                     BRAM_Rst_A,
  output logic                     BRAM_Clk_A,
  output logic                     BRAM_EN_A,
  output logic [C_NUM_WE-1:0]      BRAM_WEN_A,
  output logic [C_PORT_AWIDTH-1:0] BRAM_Addr_A,
  output logic [C_PORT_DWIDTH-1:0] BRAM_Dout_A,
  input  logic [C_PORT_DWIDTH-1:0] BRAM_Din_A
);

  // Decode window is clipped to the physical memory so a wide address range
  // can never alias onto lower words.
  localparam logic [31:0] DECODE_SPAN = C_HIGHADDR - C_BASEADDR;
  localparam logic [31:0] MEM_SPAN    = C_MEMSIZE - 1;
  localparam logic [C_PORT_AWIDTH-1:0] ADDR_SPAN =
    C_PORT_AWIDTH'((DECODE_SPAN < MEM_SPAN) ? DECODE_SPAN : MEM_SPAN);
`ifdef BRAM_INIT_SCRUB_EN
  localparam logic [C_PORT_AWIDTH-1:0] SCRUB_LAST_ADDR = C_PORT_AWIDTH'(C_MEMSIZE - 4);
`endif

  state_t                     state_q;
  logic                       init_done_q;
  logic                       en_q;
  logic [C_NUM_WE-1:0]        wen_q;
  logic [C_PORT_AWIDTH-1:0]   addr_q;
  logic [C_PORT_DWIDTH-1:0]   dout_q;

  // Two-stage request tracker: s1 = BRAM access cycle, s2 = read data cycle.
  logic s1_vld_q, s1_wr_q, s1_err_q;
  logic s2_vld_q, s2_wr_q, s2_err_q;

  logic [C_PORT_AWIDTH-1:0] addr_off;
  logic                     in_range;
  logic                     accept;
  logic [RSP_CNT_W:0]       occupancy;
  logic [RSP_CNT_W-1:0]     fifo_count;
  logic                     fifo_valid;
  rsp_t                     fifo_head;
  rsp_t                     rsp_push;

  assign BRAM_Clk_A = Clk;
  assign BRAM_Rst_A = Rst;

  assign addr_off = Req_Addr - C_PORT_AWIDTH'(C_BASEADDR);
  assign in_range = (addr_off <= ADDR_SPAN);

  // Every accepted request owns a FIFO slot from acceptance onwards, so the
  // in-flight stages count against the free space.
  assign occupancy = (RSP_CNT_W+1)'(fifo_count) + (RSP_CNT_W+1)'(s1_vld_q)
                   + (RSP_CNT_W+1)'(s2_vld_q);
  assign Req_Ready = init_done_q & ~Rst
                   & (occupancy < (RSP_CNT_W+1)'(RSP_FIFO_DEPTH));
  assign accept    = Req_Valid & Req_Ready;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= INIT;
      init_done_q <= 1'b0;
      en_q        <= 1'b0;
      wen_q       <= '0;
      addr_q      <= '0;
      dout_q      <= '0;
      s1_vld_q    <= 1'b0;
      s1_wr_q     <= 1'b0;
      s1_err_q    <= 1'b0;
      s2_vld_q    <= 1'b0;
      s2_wr_q     <= 1'b0;
      s2_err_q    <= 1'b0;
    end else begin
      en_q     <= 1'b0;
      wen_q    <= '0;
      s1_vld_q <= accept;
      s1_wr_q  <= Req_Write;
      s1_err_q <= ~in_range;
      s2_vld_q <= s1_vld_q;
      s2_wr_q  <= s1_wr_q;
      s2_err_q <= s1_err_q;

      case (state_q)
        INIT: begin
`ifdef BRAM_INIT_SCRUB_EN
          state_q <= SCRUB;
          en_q    <= 1'b1;
          wen_q   <= '1;
          addr_q  <= '0;
          dout_q  <= '0;
`else
          state_q     <= RUN;
          init_done_q <= 1'b1;
`endif
        end
`ifdef BRAM_INIT_SCRUB_EN
        SCRUB: begin
          if (addr_q == SCRUB_LAST_ADDR) begin
            state_q     <= RUN;
            init_done_q <= 1'b1;
          end else begin
            en_q   <= 1'b1;
            wen_q  <= '1;
            addr_q <= addr_q + 3'd4;
            dout_q <= '0;
          end
        end
`endif
        RUN: begin
          if (accept && in_range) begin
            en_q   <= 1'b1;
            wen_q  <= Req_Write ? Req_BE : '0;
            addr_q <= {Req_Addr[C_PORT_AWIDTH-1:2], 2'b00};
            dout_q <= Req_Data;
          end
        end
        default: begin
          state_q     <= INIT;
          init_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign Init_Done   = init_done_q;
  assign BRAM_EN_A   = en_q;
  assign BRAM_WEN_A  = wen_q;
  assign BRAM_Addr_A = addr_q;
  assign BRAM_Dout_A = dout_q;

  always_comb begin
    rsp_push     = '0;
    rsp_push.err = s2_err_q;
    if (s2_vld_q && !s2_wr_q && !s2_err_q) rsp_push.data = BRAM_Din_A;
  end

  bram_rsp_fifo u_rsp_fifo (
    .clk_i       (Clk),
    .rst_i       (Rst),
    .push_i      (s2_vld_q),
    .push_data_i (rsp_push),
    .pop_i       (Rsp_Ready & ~Rst),
    .pop_data_o  (fifo_head),
    .valid_o     (fifo_valid),
    .count_o     (fifo_count)
  );

  assign Rsp_Valid = fifo_valid & ~Rst;
  assign Rsp_Data  = Rst ? '0 : fifo_head.data;
  assign Rsp_Err   = fifo_head.err & ~Rst;

endmodule
